mult_issue_arb: RTL and testbench

//  Shares the single pipelined multiplier FU (pipe_mult_fu) between the two issue slots of the
//  2-way RS. Grants up to two mult requests per cycle into a small in-order holding queue.

---
 rtl/mult_issue_arb.sv | 140 ++++++++++++++
 tb/tb_mult_issue_arb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue_arb.sv
// Arbitrates two RS issue slots onto one pipelined multiplier through a small in-order
// holding queue, dropping branch-squashed ops and clearing resolved mask bits.
module mult_issue_arb #(
    parameter int QDEPTH  = 2,
    parameter int DATA_W  = 32,
    parameter int PREG_W  = 6,
    parameter int BMASK_W = 4,
    parameter int BS_W    = $clog2(BMASK_W),
    parameter int CTRL_W  = 8,
    parameter int CNT_W   = $clog2(QDEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              rs_req,
    input  logic [1:0][DATA_W-1:0]  rs_opA,
    input  logic [1:0][DATA_W-1:0]  rs_opB,
    input  logic [1:0][PREG_W-1:0]  rs_tagDest,
    input  logic [1:0][BMASK_W-1:0] rs_bmask,
    input  logic [1:0][CTRL_W-1:0]  rs_control,
    output logic [1:0]              arb_grant,
    input  logic                    mult_busy,
    output logic                    fus_en,
    output logic [DATA_W-1:0]       fus_opA,
    output logic [DATA_W-1:0]       fus_opB,
    output logic [PREG_W-1:0]       fus_tagDest,
    output logic [BMASK_W-1:0]      fus_bmask,
    output logic [CTRL_W-1:0]       fus_control,
    input  logic                    br_pred_wrong,
    input  logic                    br_branch_resolved,
    input  logic [BS_W-1:0]         br_bs_ptr,
    output logic [CNT_W-1:0]        arb_count
);
    localparam int IDX_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    typedef struct packed {
        logic [DATA_W-1:0]  opa;
        logic [DATA_W-1:0]  opb;
        logic [PREG_W-1:0]  tag;
        logic [BMASK_W-1:0] bmask;
        logic [CTRL_W-1:0]  ctrl;
    } entry_t;

    entry_t             q      [QDEPTH];
    entry_t             q_next [QDEPTH];
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               rr_ptr;
    logic               rr_flip;
    logic               mispredict;
    logic [BMASK_W-1:0] clr_mask;
    logic               head_valid;
    logic               pop;
    logic [1:0]         elig;
    int                 n_sq;
    int                 free;
    int                 k;

    assign mispredict = br_branch_resolved & br_pred_wrong;
    assign clr_mask   = br_branch_resolved ? (BMASK_W'(1) << br_bs_ptr) : '0;
    assign head_valid = (count != '0);
    assign arb_count  = count;

    always_comb begin
        fus_en      = head_valid & ~reset & ~(mispredict & q[0].bmask[br_bs_ptr]);
        fus_opA     = head_valid ? q[0].opa : '0;
        fus_opB     = head_valid ? q[0].opb : '0;
        fus_tagDest = head_valid ? q[0].tag : '0;
        fus_bmask   = head_valid ? (q[0].bmask & ~clr_mask) : '0;
        fus_control = head_valid ? q[0].ctrl : '0;
        pop         = fus_en & ~mult_busy;
    end

    // Squashed entries leave this cycle, so their slots count as free for incoming grants.
    always_comb begin
        n_sq = 0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (i < int'(count) && mispredict && q[IDX_W'(i)].bmask[br_bs_ptr]) begin
                n_sq = n_sq + 1;
            end
        end
        free = QDEPTH - int'(count) + int'(pop) + n_sq;

        elig[0] = rs_req[0] & ~(mispredict & rs_bmask[0][br_bs_ptr]) & ~reset;
        elig[1] = rs_req[1] & ~(mispredict & rs_bmask[1][br_bs_ptr]) & ~reset;

        arb_grant = '0;
        rr_flip   = 1'b0;
        if (elig == 2'b11) begin
            if (free >= 2) begin
                arb_grant = 2'b11;
            end else if (free == 1) begin
                arb_grant[rr_ptr] = 1'b1;
                rr_flip           = 1'b1;
            end
        end else if (elig != 2'b00 && free >= 1) begin
            arb_grant = elig;
        end
    end

    // Pop, then compact survivors in age order, then append grants (slot 0 first).
    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            q_next[IDX_W'(i)] = '0;
        end
        k = 0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (i < int'(count) && !(i == 0 && pop) &&
                !(mispredict && q[IDX_W'(i)].bmask[br_bs_ptr])) begin
                q_next[IDX_W'(k)]       = q[IDX_W'(i)];
                q_next[IDX_W'(k)].bmask = q[IDX_W'(i)].bmask & ~clr_mask;
                k = k + 1;
            end
        end
        for (int s = 0; s < 2; s++) begin
            if (arb_grant[s] && k < QDEPTH) begin
                q_next[IDX_W'(k)].opa   = rs_opA[s];
                q_next[IDX_W'(k)].opb   = rs_opB[s];
                q_next[IDX_W'(k)].tag   = rs_tagDest[s];
                q_next[IDX_W'(k)].bmask = rs_bmask[s] & ~clr_mask;
                q_next[IDX_W'(k)].ctrl  = rs_control[s];
                k = k + 1;
            end
        end
        count_next = CNT_W'(k);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q      <= '{default: '0};
            count  <= '0;
            rr_ptr <= 1'b0;
        end else begin
            q     <= q_next;
            count <= count_next;
            if (rr_flip) begin
                rr_ptr <= ~rr_ptr;
            end
        end
    end
endmodule

// File: tb/tb_mult_issue_arb.sv
// Table-driven bench for mult_issue_arb: per-cycle expected grants/issue/count from a vector
// table, with a scoreboard queue of granted ops checked against the FU-side outputs.
module tb_mult_issue_arb;
    localparam int QDEPTH = 2;

    typedef struct packed {
        logic [31:0] opa;
        logic [31:0] opb;
        logic [5:0]  tag;
        logic [3:0]  bmask;
        logic [7:0]  ctrl;
    } sb_t;

    typedef struct {
        logic [1:0] req;
        logic       busy;
        logic       res;
        logic       wrong;
        logic [1:0] ptr;
        logic [3:0] bm0;
        logic [3:0] bm1;
        logic [1:0] g;
        logic       en;
        logic [1:0] cnt;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       rs_req;
    logic [1:0][31:0] rs_opA;
    logic [1:0][31:0] rs_opB;
    logic [1:0][5:0]  rs_tagDest;
    logic [1:0][3:0]  rs_bmask;
    logic [1:0][7:0]  rs_control;
    logic [1:0]       arb_grant;
    logic             mult_busy;
    logic             fus_en;
    logic [31:0]      fus_opA;
    logic [31:0]      fus_opB;
    logic [5:0]       fus_tagDest;
    logic [3:0]       fus_bmask;
    logic [7:0]       fus_control;
    logic             br_pred_wrong;
    logic             br_branch_resolved;
    logic [1:0]       br_bs_ptr;
    logic [1:0]       arb_count;

    sb_t  sb[$];
    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mult_issue_arb #(.QDEPTH(QDEPTH)) dut (
        .clk(clk), .reset(reset),
        .rs_req(rs_req), .rs_opA(rs_opA), .rs_opB(rs_opB), .rs_tagDest(rs_tagDest),
        .rs_bmask(rs_bmask), .rs_control(rs_control), .arb_grant(arb_grant),
        .mult_busy(mult_busy), .fus_en(fus_en), .fus_opA(fus_opA), .fus_opB(fus_opB),
        .fus_tagDest(fus_tagDest), .fus_bmask(fus_bmask), .fus_control(fus_control),
        .br_pred_wrong(br_pred_wrong), .br_branch_resolved(br_branch_resolved),
        .br_bs_ptr(br_bs_ptr), .arb_count(arb_count)
    );

    function automatic vec_t mk(input logic [1:0] req, input logic busy, input logic res,
                                input logic wrong, input logic [1:0] ptr, input logic [3:0] bm0,
                                input logic [3:0] bm1, input logic [1:0] g, input logic en,
                                input logic [1:0] cnt);
        vec_t v;
        v.req = req; v.busy = busy; v.res = res; v.wrong = wrong; v.ptr = ptr;
        v.bm0 = bm0; v.bm1 = bm1; v.g = g; v.en = en; v.cnt = cnt;
        return v;
    endfunction

    function automatic sb_t op_of(input int idx, input int s, input logic [3:0] bm);
        sb_t e;
        e.opa   = 32'hA000_0000 | 32'(idx << 4) | 32'(s);
        e.opb   = 32'hB000_0000 | 32'(idx << 4) | 32'(s);
        e.tag   = 6'(idx * 2 + s);
        e.bmask = bm;
        e.ctrl  = 8'(128 + idx * 2 + s);
        return e;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        sb_t        e0, e1;
        logic [3:0] clr;
        @(negedge clk);
        e0 = op_of(idx, 0, v.bm0);
        e1 = op_of(idx, 1, v.bm1);
        rs_req = v.req; mult_busy = v.busy;
        br_branch_resolved = v.res; br_pred_wrong = v.wrong; br_bs_ptr = v.ptr;
        rs_opA = {e1.opa, e0.opa}; rs_opB = {e1.opb, e0.opb};
        rs_tagDest = {e1.tag, e0.tag}; rs_bmask = {e1.bmask, e0.bmask};
        rs_control = {e1.ctrl, e0.ctrl};
        #1;
        clr = v.res ? (4'b0001 << v.ptr) : 4'b0000;
        check_output($sformatf("grant[%0d]", idx), 64'(arb_grant), 64'(v.g));
        check_output($sformatf("fus_en[%0d]", idx), 64'(fus_en), 64'(v.en));
        if (v.en) begin
            if (sb.size() == 0) begin
                check_output($sformatf("sb_nonempty[%0d]", idx), 64'(0), 64'(1));
            end else begin
                check_output($sformatf("fus_opA[%0d]", idx), 64'(fus_opA), 64'(sb[0].opa));
                check_output($sformatf("fus_opB[%0d]", idx), 64'(fus_opB), 64'(sb[0].opb));
                check_output($sformatf("fus_tag[%0d]", idx), 64'(fus_tagDest), 64'(sb[0].tag));
                check_output($sformatf("fus_bmask[%0d]", idx), 64'(fus_bmask),
                             64'(sb[0].bmask & ~clr));
                check_output($sformatf("fus_ctrl[%0d]", idx), 64'(fus_control), 64'(sb[0].ctrl));
            end
        end
        if (v.en && !v.busy && sb.size() > 0) sb.pop_front();
        if (v.res && v.wrong) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].bmask[v.ptr]) sb.delete(i);
            end
        end
        foreach (sb[i]) sb[i].bmask = sb[i].bmask & ~clr;
        if (v.g[0]) begin e0.bmask = e0.bmask & ~clr; sb.push_back(e0); end
        if (v.g[1]) begin e1.bmask = e1.bmask & ~clr; sb.push_back(e1); end
        @(posedge clk);
        #1;
        check_output($sformatf("count[%0d]", idx), 64'(arb_count), 64'(v.cnt));
    endtask

    initial begin
        // Single grant, then two-way contention with round-robin refill.
        vecs.push_back(mk(2'b01, 0, 0, 0, 0, 4'h0, 4'h0, 2'b01, 0, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 1, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0));
        vecs.push_back(mk(2'b11, 1, 0, 0, 0, 4'h0, 4'h0, 2'b11, 0, 2));
        vecs.push_back(mk(2'b11, 1, 0, 0, 0, 4'h0, 4'h0, 2'b00, 1, 2));
        vecs.push_back(mk(2'b11, 1, 0, 0, 0, 4'h0, 4'h0, 2'b00, 1, 2));
        vecs.push_back(mk(2'b11, 0, 0, 0, 0, 4'h0, 4'h0, 2'b01, 1, 2));
        vecs.push_back(mk(2'b11, 0, 0, 0, 0, 4'h0, 4'h0, 2'b10, 1, 2));
        vecs.push_back(mk(2'b11, 0, 0, 0, 0, 4'h0, 4'h0, 2'b01, 1, 2));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 1, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 1, 0));
        // Mispredict squashes the stalled head and blocks a request carrying the same bit.
        vecs.push_back(mk(2'b11, 1, 0, 0, 0, 4'h2, 4'h0, 2'b11, 0, 2));
        vecs.push_back(mk(2'b01, 1, 1, 1, 1, 4'h2, 4'h0, 2'b00, 0, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 1, 0));
        // Correct resolve clears the bit in storage and on the FU output.
        vecs.push_back(mk(2'b01, 1, 0, 0, 0, 4'h6, 4'h0, 2'b01, 0, 1));
        vecs.push_back(mk(2'b00, 1, 1, 0, 2, 4'h0, 4'h0, 2'b00, 1, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 1, 0));
        // Five-cycle stall keeps the head stable.
        vecs.push_back(mk(2'b01, 0, 0, 0, 0, 4'h0, 4'h0, 2'b01, 0, 1));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(2'b00, 1, 0, 0, 0, 4'h0, 4'h0, 2'b00, 1, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 1, 0));
        // Resolve bit cleared on an op as it is enqueued.
        vecs.push_back(mk(2'b01, 1, 1, 0, 0, 4'h3, 4'h0, 2'b01, 0, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 1, 0));
        // Squash of the younger entry behind a live head.
        vecs.push_back(mk(2'b11, 1, 0, 0, 0, 4'h0, 4'h8, 2'b11, 0, 2));
        vecs.push_back(mk(2'b00, 1, 1, 1, 3, 4'h0, 4'h0, 2'b00, 1, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 1, 0));
        // Lone request into the last free slot.
        vecs.push_back(mk(2'b01, 1, 0, 0, 0, 4'h0, 4'h0, 2'b01, 0, 1));
        vecs.push_back(mk(2'b10, 1, 0, 0, 0, 4'h0, 4'h0, 2'b10, 1, 2));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 1, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 1, 0));
        vecs.push_back(mk(2'b11, 1, 0, 0, 0, 4'h0, 4'h0, 2'b11, 0, 2));

        reset = 1'b1; rs_req = 2'b11; mult_busy = 1'b0;
        br_branch_resolved = 1'b0; br_pred_wrong = 1'b0; br_bs_ptr = 2'd0;
        rs_opA = '0; rs_opB = '0; rs_tagDest = '0; rs_bmask = '0; rs_control = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_grant", 64'(arb_grant), 64'(0));
        check_output("reset_count", 64'(arb_count), 64'(0));
        check_output("reset_fus_en", 64'(fus_en), 64'(0));
        check_output("reset_fus_opA", 64'(fus_opA), 64'(0));
        reset = 1'b0; rs_req = 2'b00;

        foreach (vecs[i]) apply_stimulus(vecs[i], i);

        // Reset with a full queue empties it on the next edge.
        @(negedge clk);
        reset = 1'b1; rs_req = 2'b11; mult_busy = 1'b0;
        #1;
        check_output("midreset_grant", 64'(arb_grant), 64'(0));
        @(posedge clk);
        #1;
        check_output("midreset_count", 64'(arb_count), 64'(0));
        @(negedge clk);
        reset = 1'b0; rs_req = 2'b00;
        sb.delete();
        #1;
        check_output("postreset_fus_en", 64'(fus_en), 64'(0));
        check_output("postreset_grant", 64'(arb_grant), 64'(0));
        check_output("postreset_fus_opA", 64'(fus_opA), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
